// File: rtl/pipeline_pkg.sv
// Types and constants shared by the front-end pipeline blocks.
// fetch_entry_t is the {pc, instr} pair carried between fetch and decode.
package pipeline_pkg;

  localparam int unsigned XLEN      = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer_ram.sv
// Fetch buffer storage: DEPTH entries, synchronous write, asynchronous read.
module fetch_buffer_ram
  import pipeline_pkg::*;
#(
  parameter  int unsigned DEPTH   = 4,
  parameter  type         entry_t = fetch_entry_t,
  localparam int unsigned AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  entry_t        wdata,
  input  logic [AW-1:0] raddr,
  output entry_t        rdata
);

  entry_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_buffer.sv
// Fetch-to-decode FIFO of {pc, instr} pairs with flush and synchronous reset.
// Define FETCH_BUFFER_BYPASS_EN to forward a fetch straight to decode when empty.
module fetch_buffer
  import pipeline_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  parameter  int unsigned XLEN  = pipeline_pkg::XLEN,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic            CLK,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_instr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_instr,
  output logic [CW-1:0]   count
);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } entry_t;

  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;

  logic   empty;
  logic   bypass;
  logic   push;
  logic   pop;
  entry_t wentry;
  entry_t head;

  assign empty    = (count_q == '0);
  assign in_ready = (count_q < CW'(DEPTH));

`ifdef FETCH_BUFFER_BYPASS_EN
  assign bypass = empty && in_valid && !flush;
`else
  assign bypass = 1'b0;
`endif

  // A bypassed pair that decode takes this cycle never enters storage.
  assign push = in_valid && in_ready && !(bypass && out_ready);
  assign pop  = !empty && out_ready;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push) wptr_d = wptr_q + AW'(1);
      if (pop)  rptr_d = rptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  assign wentry.pc    = in_pc;
  assign wentry.instr = in_instr;

  fetch_buffer_ram #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_ram (
    .clk   (CLK),
    .we    (push && !flush && !rst),
    .waddr (wptr_q),
    .wdata (wentry),
    .raddr (rptr_q),
    .rdata (head)
  );

  always_comb begin
    out_valid = !empty;
    out_pc    = head.pc;
    out_instr = head.instr;
    if (bypass) begin
      out_valid = 1'b1;
      out_pc    = in_pc;
      out_instr = in_instr;
    end else if (empty) begin
      out_pc    = '0;
      out_instr = XLEN'(NOP_INSTR);
    end
  end

  assign count = count_q;

endmodule
